// File: rtl/audio_sched.sv
// rtl/audio_sched.sv - arbitrates game sound requests onto the single audio controller
// Define AUDIO_SCHED_RR_EN for round-robin arbitration; default is fixed priority (requester 0 highest).
module audio_sched #(
  parameter int NUM_REQ     = 4,
  parameter int IDX_W       = 16,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*IDX_W-1:0] req_index,
  input  logic                     cntrl_ready,
  output logic [IDX_W-1:0]         audio_index,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       pending,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout
);
  localparam int W_PTR = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, ACK, PLAY} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q [NUM_REQ];
  logic [W_PTR-1:0] win;
  logic             found;
  logic [CNT_W-1:0] cnt_q;
  logic             go_issue, go_done, go_timeout;

  assign busy = (state_q != IDLE);

`ifdef AUDIO_SCHED_RR_EN
  logic [W_PTR-1:0] ptr_q;
  logic [W_PTR-1:0] sel;
  int               j;

  // Search begins just past the last winner so every requester gets a turn.
  always_comb begin
    win   = '0;
    found = 1'b0;
    sel   = '0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr_q) + 1 + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      sel = W_PTR'(j);
      if (!found && pending[sel]) begin
        found = 1'b1;
        win   = sel;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= W_PTR'(NUM_REQ - 1);
    else if (go_issue) ptr_q <= win;
  end
`else
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && pending[i]) begin
        found = 1'b1;
        win   = W_PTR'(i);
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    go_issue   = 1'b0;
    go_done    = 1'b0;
    go_timeout = 1'b0;
    if (en) begin
      case (state_q)
        IDLE: begin
          if (found && cntrl_ready) begin
            state_d  = ISSUE;
            go_issue = 1'b1;
          end
        end
        ISSUE: state_d = ACK;
        ACK: begin
          if (!cntrl_ready) begin
            state_d = PLAY;
          end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
            state_d    = IDLE;
            go_timeout = 1'b1;
          end
        end
        PLAY: begin
          if (cntrl_ready) begin
            state_d = IDLE;
            go_done = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      audio_index <= '0;
      grant       <= '0;
      pending     <= '0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      cnt_q       <= '0;
      for (int i = 0; i < NUM_REQ; i++) idx_q[i] <= '0;
    end else begin
      done    <= go_done;
      timeout <= go_timeout;
      if (go_issue) begin
        audio_index <= idx_q[win];
        grant       <= NUM_REQ'(1) << win;
      end
      if (en && state_q == ISSUE) begin
        audio_index <= '0;
        cnt_q       <= '0;
      end
      if (en && state_q == ACK && cntrl_ready) cnt_q <= cnt_q + 1'b1;
      if (go_done || go_timeout) grant <= '0;
      // A fresh capture outranks the clear of the entry being issued.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req[i] && (req_index[i*IDX_W +: IDX_W] != '0)) begin
          pending[i] <= 1'b1;
          idx_q[i]   <= req_index[i*IDX_W +: IDX_W];
        end else if (go_issue && (win == W_PTR'(i))) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

endmodule
